// File: rtl/vec_mem_pkg.sv
// Shared defaults, state encoding and sizing helpers for the vector memory
// controller and its response buffer.
package vec_mem_pkg;

  // Default geometry of the data memory: one wide word per address.
  localparam int WIDTH_V_DEFAULT      = 256;
  localparam int ADDR_W_DEFAULT       = 14;
  localparam int BYTENNA_SIZE_DEFAULT = WIDTH_V_DEFAULT / 8;

  // Burst length field: beats minus one, so 1..16 words per request.
  localparam int LEN_W = 4;

  // Controller states. READ issues memory reads; DRAIN waits for the
  // outstanding reads and buffered responses to leave the block.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Response buffer depth: room for every read the memory can have in
  // flight plus two entries, which lets reads issue back to back while the
  // consumer keeps up.
  function automatic int rsp_depth(input int read_lat);
    return read_lat + 2;
  endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Small synchronous FIFO holding load responses until the consumer takes
// them. Depth need not be a power of two; pointers wrap explicitly.
module rsp_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 3,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = storage[rd_ptr];

  // Data array: write the pushed entry at the tail.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  // NOTE: the data array is deliberately not reset; validity is carried by
  // the pointers and count, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      storage[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vec_mem_ctrl.sv
// Vector memory controller: turns burst load/store requests into
// word-by-word accesses on a single-port data memory with fixed read
// latency, and streams load data back through a small response FIFO.
module vec_mem_ctrl
  import vec_mem_pkg::*;
#(
  parameter int  WIDTH_V      = WIDTH_V_DEFAULT,
  parameter int  ADDR_W       = ADDR_W_DEFAULT,
  parameter int  READ_LAT     = 1,
  localparam int BYTENNA_SIZE = WIDTH_V / 8
) (
  input  logic                    clk,
  input  logic                    reset,
  // request channel
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [LEN_W-1:0]        req_len,
  input  logic [BYTENNA_SIZE-1:0] req_mask,
  // store data channel
  input  logic [WIDTH_V-1:0]      wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  // load response channel
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WIDTH_V-1:0]      rsp_data,
  output logic                    rsp_last,
  // data memory port
  output logic [ADDR_W-1:0]       mem_address,
  output logic [BYTENNA_SIZE-1:0] mem_byteena,
  output logic [WIDTH_V-1:0]      mem_data,
  output logic                    mem_rden,
  output logic                    mem_wren,
  input  logic [WIDTH_V-1:0]      mem_q
);

  localparam int DEPTH = rsp_depth(READ_LAT);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Burst context latched at request acceptance.
  state_e                  state;
  logic [ADDR_W-1:0]       addr;
  logic [LEN_W-1:0]        len;
  logic [LEN_W-1:0]        beat;
  logic [BYTENNA_SIZE-1:0] mask;
  logic                    req_ready_q;
  logic                    wr_ready_q;

  // Read-return tracking: one valid/last bit per memory pipeline stage.
  logic [READ_LAT-1:0]     pipe_vld;
  logic [READ_LAT-1:0]     pipe_last;
  logic [CNT_W-1:0]        inflight;

  // Response buffer view.
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_empty;
  logic [WIDTH_V:0]        fifo_head;

  logic                    accept;
  logic                    wr_fire;
  logic                    last_beat;
  logic                    room;
  logic                    issue;
  logic                    capture;
  logic                    pop;

  // Every externally visible control is forced low while reset is held, so
  // the memory and both neighbours see a quiet port in the reset cycle.
  assign req_ready = req_ready_q && reset;
  assign wr_ready  = wr_ready_q && reset;
  assign accept    = req_valid && req_ready;
  assign wr_fire   = wr_valid && wr_ready;
  assign last_beat = (beat == len);

  // A read may issue only if, counting it, buffered plus outstanding reads
  // still fit in the FIFO; the FIFO therefore can never be asked to take a
  // word it has no room for, whatever the consumer does.
  assign room    = (int'(fifo_count) + int'(inflight)) < DEPTH;
  assign issue   = (state == READ) && reset && room;
  assign capture = pipe_vld[READ_LAT-1];

  assign rsp_valid = !fifo_empty && reset;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = rsp_valid ? fifo_head[WIDTH_V-1:0] : '0;
  assign rsp_last  = rsp_valid && fifo_head[WIDTH_V];

  // Memory port: stores pass through in the handshake cycle, reads use the
  // full word enable; otherwise the port is idle and driven to zero.
  // NOTE: every output of this block is given a default before any branch,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    mem_rden    = issue;
    mem_wren    = wr_fire && (mask != '0);
    mem_address = '0;
    mem_byteena = '0;
    mem_data    = '0;
    if (wr_fire) begin
      mem_address = addr;
      mem_byteena = mask;
      mem_data    = wr_data;
    end else if (issue) begin
      mem_address = addr;
      mem_byteena = '1;
    end
  end

  // Track issued reads through the memory latency and count them until
  // their data lands in the FIFO; reset drops anything still returning.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
      inflight  <= '0;
    end else begin
      pipe_vld[0]  <= issue;
      pipe_last[0] <= issue && last_beat;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
      case ({issue, capture})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Returned words carry their last-beat tag alongside the data.
  rsp_fifo #(
    .WIDTH (WIDTH_V + 1),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (capture),
    .push_data ({pipe_last[READ_LAT-1], mem_q}),
    .pop       (pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Burst sequencer with registered channel-ready outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      addr        <= '0;
      len         <= '0;
      beat        <= '0;
      mask        <= '0;
      req_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr        <= req_addr;
            len         <= req_len;
            mask        <= req_mask;
            beat        <= '0;
            req_ready_q <= 1'b0;
            if (req_we) begin
              state      <= WRITE;
              wr_ready_q <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end

        WRITE: begin
          if (wr_fire) begin
            if (last_beat) begin
              state       <= IDLE;
              wr_ready_q  <= 1'b0;
              req_ready_q <= 1'b1;
            end else begin
              beat <= beat + 1'b1;
              addr <= addr + 1'b1;
            end
          end
        end

        READ: begin
          if (issue) begin
            if (last_beat) begin
              state <= DRAIN;
            end else begin
              beat <= beat + 1'b1;
              addr <= addr + 1'b1;
            end
          end
        end

        DRAIN: begin
          if (inflight == '0 && fifo_empty) begin
            state       <= IDLE;
            req_ready_q <= 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          req_ready_q <= 1'b1;
          wr_ready_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_mem_ctrl.sv
// Self-checking bench for vec_mem_ctrl: directed bursts against a
// behavioural data memory, with scoreboards for memory writes, read
// addresses and load responses.
module tb_vec_mem_ctrl;
  import vec_mem_pkg::*;

  localparam int WV        = 256;
  localparam int AW        = 14;
  localparam int LAT       = 1;
  localparam int BE        = WV / 8;
  localparam int MEM_WORDS = 1 << AW;
  localparam logic [WV-1:0] POISON = {8{32'hDEAD_BEEF}};

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [3:0]    req_len;
  logic [BE-1:0] req_mask;
  logic [WV-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [WV-1:0] rsp_data;
  logic          rsp_last;
  logic [AW-1:0] mem_address;
  logic [BE-1:0] mem_byteena;
  logic [WV-1:0] mem_data;
  logic          mem_rden;
  logic          mem_wren;
  logic [WV-1:0] mem_q;

  always #5 clk = ~clk;

  vec_mem_ctrl #(
    .WIDTH_V  (WV),
    .ADDR_W   (AW),
    .READ_LAT (LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .req_mask    (req_mask),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_last    (rsp_last),
    .mem_address (mem_address),
    .mem_byteena (mem_byteena),
    .mem_data    (mem_data),
    .mem_rden    (mem_rden),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q)
  );

  // Device-side memory with LAT cycles of read latency.
  logic [WV-1:0] ram     [MEM_WORDS];
  logic [WV-1:0] ref_mem [MEM_WORDS];
  logic [WV-1:0] q_stage [LAT];

  always @(posedge clk) begin
    if (mem_wren) begin
      for (int b = 0; b < BE; b++) begin
        if (mem_byteena[b]) ram[mem_address][b*8 +: 8] <= mem_data[b*8 +: 8];
      end
    end
    q_stage[0] <= mem_rden ? ram[mem_address] : POISON;
    for (int i = 1; i < LAT; i++) q_stage[i] <= q_stage[i-1];
  end
  assign mem_q = q_stage[LAT-1];

  // Scoreboards.
  typedef struct { logic [WV-1:0] data; logic last; } rsp_t;
  typedef struct { logic [AW-1:0] addr; logic [BE-1:0] be; logic [WV-1:0] data; } wr_t;

  rsp_t          rsp_q[$];
  wr_t           wr_q[$];
  logic [AW-1:0] rd_addr_q[$];

  int errors = 0;
  int checks = 0;
  int wren_cnt = 0;
  int rsp_cnt = 0;

  task automatic check(input string tag, input logic [WV-1:0] obs, input logic [WV-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor, sampling on the falling edge.
  rsp_t          mon_r;
  wr_t           mon_w;
  logic [AW-1:0] mon_a;
  logic          stall_prev = 1'b0;
  logic [WV-1:0] held_data;

  always @(negedge clk) begin
    if (reset) begin
      if (mem_rden || mem_wren) check("rden_wren_exclusive", WV'(mem_rden && mem_wren), WV'(0));
      if (mem_wren) begin
        wren_cnt++;
        if (wr_q.size() == 0) check("wr_unexpected", WV'(mem_wren), WV'(0));
        else begin
          mon_w = wr_q.pop_front();
          check("wr_addr", WV'(mem_address), WV'(mon_w.addr));
          check("wr_byteena", WV'(mem_byteena), WV'(mon_w.be));
          check("wr_data", mem_data, mon_w.data);
        end
      end
      if (mem_rden) begin
        check("rd_byteena", WV'(mem_byteena), {{(WV-BE){1'b0}}, {BE{1'b1}}});
        if (rd_addr_q.size() == 0) check("rd_unexpected", WV'(mem_rden), WV'(0));
        else begin
          mon_a = rd_addr_q.pop_front();
          check("rd_addr", WV'(mem_address), WV'(mon_a));
        end
      end
      if (stall_prev) begin
        check("rsp_hold_valid", WV'(rsp_valid), WV'(1));
        check("rsp_hold_data", rsp_data, held_data);
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        if (rsp_q.size() == 0) check("rsp_unexpected", WV'(rsp_valid), WV'(0));
        else begin
          mon_r = rsp_q.pop_front();
          check("rsp_data", rsp_data, mon_r.data);
          check("rsp_last", WV'(rsp_last), WV'(mon_r.last));
        end
      end
      stall_prev = rsp_valid && !rsp_ready;
      held_data  = rsp_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Offer a request from a point just after a rising edge; returns just
  // after the accepting edge.
  task automatic request(input logic we, input logic [AW-1:0] a, input logic [3:0] len,
                         input logic [BE-1:0] mask);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_len   = len;
    req_mask  = mask;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_ready_timeout", WV'(req_ready), WV'(1));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [3:0] len, input logic [BE-1:0] mask,
                       input logic [WV-1:0] d0, input bit stall);
    logic [AW-1:0] wa;
    logic [WV-1:0] d;
    wr_t           w;
    int            n;
    for (int b = 0; b <= int'(len); b++) begin
      wa = a + AW'(b);
      d  = d0 ^ {8{32'(b)}};
      if (mask != '0) begin
        w.addr = wa;
        w.be   = mask;
        w.data = d;
        wr_q.push_back(w);
      end
      for (int k = 0; k < BE; k++) begin
        if (mask[k]) ref_mem[wa][k*8 +: 8] = d[k*8 +: 8];
      end
    end
    request(1'b1, a, len, mask);
    for (int b = 0; b <= int'(len); b++) begin
      if (stall) begin
        wr_valid = 1'b0;
        @(negedge clk);
        check("wr_stall_ready", WV'(wr_ready), WV'(1));
        check("wr_stall_wren", WV'(mem_wren), WV'(0));
        @(posedge clk);
        #1;
      end
      wr_valid = 1'b1;
      wr_data  = d0 ^ {8{32'(b)}};
      n = 0;
      @(negedge clk);
      while (!wr_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!wr_ready) check("wr_ready_timeout", WV'(wr_ready), WV'(1));
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ready_mode 0: consumer always ready; 1: ready one cycle in three.
  task automatic load(input logic [AW-1:0] a, input logic [3:0] len, input int ready_mode);
    rsp_t          r;
    logic [AW-1:0] ra;
    int            n;
    int            start_cnt;
    start_cnt = rsp_cnt;
    for (int b = 0; b <= int'(len); b++) begin
      ra = a + AW'(b);
      rd_addr_q.push_back(ra);
      r.data = ref_mem[ra];
      r.last = (b == int'(len));
      rsp_q.push_back(r);
    end
    rsp_ready = (ready_mode == 0);
    request(1'b0, a, len, '1);
    n = 0;
    while ((rsp_q.size() != 0 || !req_ready) && n < 300) begin
      rsp_ready = (ready_mode == 0) || (n % 3 == 0);
      @(posedge clk);
      #1;
      n++;
    end
    rsp_ready = 1'b1;
    check("load_pending", WV'(rsp_q.size()), WV'(0));
    check("load_beats", WV'(rsp_cnt - start_cnt), WV'(int'(len) + 1));
    check("load_idle_ready", WV'(req_ready), WV'(1));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_req_ready"}, WV'(req_ready), WV'(0));
    check({tag, "_wr_ready"}, WV'(wr_ready), WV'(0));
    check({tag, "_rsp_valid"}, WV'(rsp_valid), WV'(0));
    check({tag, "_rsp_last"}, WV'(rsp_last), WV'(0));
    check({tag, "_mem_rden"}, WV'(mem_rden), WV'(0));
    check({tag, "_mem_wren"}, WV'(mem_wren), WV'(0));
    check({tag, "_mem_byteena"}, WV'(mem_byteena), WV'(0));
    check({tag, "_mem_address"}, WV'(mem_address), WV'(0));
    check({tag, "_mem_data"}, mem_data, WV'(0));
    check({tag, "_rsp_data"}, rsp_data, WV'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            wc;
    logic [WV-1:0] d;

    for (int i = 0; i < MEM_WORDS; i++) begin
      ram[i]     = {8{32'hD000_0000 | 32'(i)}};
      ref_mem[i] = {8{32'hD000_0000 | 32'(i)}};
    end
    reset     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    req_mask  = '0;
    wr_data   = '0;
    wr_valid  = 1'b0;
    rsp_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_req_ready", WV'(req_ready), WV'(1));
    @(posedge clk);
    #1;

    // Single full-mask store to word 0.
    wc = wren_cnt;
    store(14'd0, 4'd0, '1, {32{8'hCC}}, 1'b0);
    check("store0_wren_cycles", WV'(wren_cnt - wc), WV'(1));

    // Single store of 0x55.. to word 5.
    store(14'd5, 4'd0, '1, {32{8'h55}}, 1'b0);

    // Partial-mask store to word 8: only bytes 8..11 change.
    d = {8{32'h1111_1111}};
    d[95:64] = 32'hBACA_DECA;
    store(14'd8, 4'd0, 32'h0000_0F00, d, 1'b0);
    load(14'd8, 4'd0, 0);

    // Ten-beat load across the stored words, consumer always ready.
    load(14'd0, 4'd9, 0);

    // Sixteen-beat load with a slow consumer.
    load(14'd0, 4'd15, 1);

    // Load wrapping past the top of the address space.
    load(14'd16380, 4'd5, 0);

    // All-zero mask store: handshakes only, no memory writes.
    wc = wren_cnt;
    store(14'd40, 4'd2, '0, {WV{1'b1}}, 1'b0);
    check("zero_mask_wren_cycles", WV'(wren_cnt - wc), WV'(0));
    load(14'd40, 4'd2, 0);

    // Multi-beat partial store with a stall before every beat.
    wc = wren_cnt;
    store(14'd30, 4'd3, 32'hF0F0_000F, {8{32'h600D_F00D}}, 1'b1);
    check("stall_store_wren_cycles", WV'(wren_cnt - wc), WV'(4));
    load(14'd30, 4'd3, 1);

    // Reset in the middle of a stalled read burst.
    for (int b = 0; b < 16; b++) rd_addr_q.push_back(AW'(100 + b));
    rsp_ready = 1'b0;
    request(1'b0, 14'd100, 4'd15, '1);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_quiet("midreset_same");
    @(posedge clk);
    #1;
    rsp_q.delete();
    rd_addr_q.delete();
    @(negedge clk);
    check_quiet("midreset_next");
    @(posedge clk);
    #1;
    reset     = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("release_req_ready", WV'(req_ready), WV'(1));
    repeat (3) begin
      @(negedge clk);
      check("release_no_rsp", WV'(rsp_valid), WV'(0));
    end
    @(posedge clk);
    #1;

    // Normal operation after the abort.
    load(14'd100, 4'd3, 0);

    check("wr_queue_empty", WV'(wr_q.size()), WV'(0));
    check("rd_queue_empty", WV'(rd_addr_q.size()), WV'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
